// File: rtl/hubris_pkg.sv
// Shared decode constants, scoreboard entry type and opcode classification
// for the Hubris RV32I issue stage.
package hubris_pkg;

   localparam int RF_ADDR_W = 5;

   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;

   localparam logic [31:0] INVALID_INST = 32'hC0001073;

   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] rd;
      logic                 is_load;
   } sb_entry_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } halt_state_t;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return (opcode == OPCODE_OP) || (opcode == OPCODE_BRANCH) || (opcode == OPCODE_STORE) ||
             (opcode == OPCODE_OP_IMM) || (opcode == OPCODE_JALR) || (opcode == OPCODE_LOAD);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OPCODE_OP) || (opcode == OPCODE_BRANCH) || (opcode == OPCODE_STORE);
   endfunction

   function automatic logic writes_rd(input logic [6:0] opcode);
      return (opcode == OPCODE_OP) || (opcode == OPCODE_OP_IMM) || (opcode == OPCODE_LUI) ||
             (opcode == OPCODE_AUIPC) || (opcode == OPCODE_LOAD) || (opcode == OPCODE_JAL) ||
             (opcode == OPCODE_JALR);
   endfunction

endpackage

// File: rtl/rd_scoreboard.sv
// Shift register of in-flight register writers; slot 0 is the youngest and
// the last slot retires each cycle. Reports per-slot matches against rs1/rs2.
module rd_scoreboard
   import hubris_pkg::*;
#(
   parameter int WB_DEPTH   = 2,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  sb_entry_t             push,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic [WB_DEPTH-1:0]   match_rs1,
   output logic [WB_DEPTH-1:0]   match_rs2,
   output logic [WB_DEPTH-1:0]   load_slot
);

   sb_entry_t slot_q [WB_DEPTH];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < WB_DEPTH; i++) slot_q[i] <= '0;
      end else begin
         slot_q[0] <= push;
         for (int i = 1; i < WB_DEPTH; i++) slot_q[i] <= slot_q[i-1];
      end
   end

   always_comb begin
      match_rs1 = '0;
      match_rs2 = '0;
      load_slot = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         match_rs1[i] = slot_q[i].valid && (slot_q[i].rd == rs1);
         match_rs2[i] = slot_q[i].valid && (slot_q[i].rd == rs2);
         load_slot[i] = slot_q[i].valid && slot_q[i].is_load;
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Issue-stage hazard and halt controller: data-dependency stalls from the rd
// scoreboard, control-transfer penalty counter, and the halt-drain FSM.
module hazard_sequencer
   import hubris_pkg::*;
#(
   parameter int INST_WIDTH     = 32,
   parameter int REG_ADDR_W     = 5,
   parameter int WB_DEPTH       = 2,
   parameter int FWD_EN         = 0,
   parameter int LOAD_USE_WIN   = 1,
   parameter int BRANCH_PENALTY = 1,
   parameter int JUMP_PENALTY   = 1,
   parameter int HALT_DRAIN     = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  id_valid,
   input  logic [INST_WIDTH-1:0] id_inst,
   output logic                  stall_id_if_pl,
   output logic                  stall_pc_increment,
   output logic                  halt,
   output logic                  dbg_dep_stall,
   output logic                  dbg_ctrl_stall
);

   localparam int CNT_W = 8;

   logic [6:0]            opcode;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   logic [WB_DEPTH-1:0]   match_rs1, match_rs2, load_slot;
   logic                  use_rs1, use_rs2, dep_hit, stall, issue, halt_inst;
   sb_entry_t             push;
   logic [CNT_W-1:0]      ctrl_cnt_q, drain_cnt_q, drain_cnt_d;
   halt_state_t           state_q, state_d;

   assign opcode    = id_inst[6:0];
   assign rs1       = id_inst[15 +: REG_ADDR_W];
   assign rs2       = id_inst[20 +: REG_ADDR_W];
   assign rd        = id_inst[7 +: REG_ADDR_W];
   assign halt_inst = (id_inst == INST_WIDTH'(INVALID_INST));

   // Handshake: ID instruction advances (issue) only when id_valid is high and
   // stall is low; a stalled instruction stays in ID and EX receives a bubble.
   assign stall = (state_q != ST_RUN) || (ctrl_cnt_q != '0) || dep_hit;
   assign issue = id_valid && !stall;

   always_comb begin
      push = '0;
      if (issue && writes_rd(opcode) && (rd != '0)) begin
         push.valid   = 1'b1;
         push.rd      = rd;
         push.is_load = (opcode == OPCODE_LOAD);
      end
   end

   rd_scoreboard #(
      .WB_DEPTH   (WB_DEPTH),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_rd_scoreboard (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .rs1       (rs1),
      .rs2       (rs2),
      .match_rs1 (match_rs1),
      .match_rs2 (match_rs2),
      .load_slot (load_slot)
   );

   // With forwarding only young load results are still unavailable to ID.
   always_comb begin
      use_rs1 = uses_rs1(opcode) && (rs1 != '0);
      use_rs2 = uses_rs2(opcode) && (rs2 != '0);
      dep_hit = 1'b0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if ((FWD_EN == 0) || (load_slot[i] && (i < LOAD_USE_WIN))) begin
            if ((use_rs1 && match_rs1[i]) || (use_rs2 && match_rs2[i])) dep_hit = 1'b1;
         end
      end
      dep_hit = dep_hit && id_valid;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_cnt_q <= '0;
      end else if (issue && (opcode == OPCODE_BRANCH)) begin
         ctrl_cnt_q <= CNT_W'(BRANCH_PENALTY);
      end else if (issue && ((opcode == OPCODE_JAL) || (opcode == OPCODE_JALR))) begin
         ctrl_cnt_q <= CNT_W'(JUMP_PENALTY);
      end else if (ctrl_cnt_q != '0) begin
         ctrl_cnt_q <= ctrl_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (issue && halt_inst) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = CNT_W'(HALT_DRAIN - 1);
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == '0) state_d = ST_HALTED;
            else                   drain_cnt_d = drain_cnt_q - 1'b1;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   assign stall_id_if_pl     = stall;
   assign stall_pc_increment = stall;
   assign halt               = (state_q == ST_HALTED);
   assign dbg_dep_stall      = dep_hit;
   assign dbg_ctrl_stall     = (ctrl_cnt_q != '0);

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: five configurations share one stimulus stream;
// directed scenarios plus a random stream checked against an in-flight-writer model.
module tb_hazard_sequencer;

   localparam int NI = 5;
   localparam logic [31:0] INV = 32'hC0001073;
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUI = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                          OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          id_valid = 1'b0;
   logic [31:0]   id_inst = '0;
   logic [NI-1:0] stall_v, pc_v, halt_v, dep_v, ctl_v;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   hazard_sequencer u_def (.clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_inst(id_inst),
      .stall_id_if_pl(stall_v[0]), .stall_pc_increment(pc_v[0]), .halt(halt_v[0]),
      .dbg_dep_stall(dep_v[0]), .dbg_ctrl_stall(ctl_v[0]));
   hazard_sequencer #(.FWD_EN(1), .LOAD_USE_WIN(1)) u_fwd (.clk(clk), .reset_n(reset_n),
      .id_valid(id_valid), .id_inst(id_inst), .stall_id_if_pl(stall_v[1]), .stall_pc_increment(pc_v[1]),
      .halt(halt_v[1]), .dbg_dep_stall(dep_v[1]), .dbg_ctrl_stall(ctl_v[1]));
   hazard_sequencer #(.BRANCH_PENALTY(3), .JUMP_PENALTY(0), .HALT_DRAIN(3)) u_br (.clk(clk),
      .reset_n(reset_n), .id_valid(id_valid), .id_inst(id_inst), .stall_id_if_pl(stall_v[2]),
      .stall_pc_increment(pc_v[2]), .halt(halt_v[2]), .dbg_dep_stall(dep_v[2]), .dbg_ctrl_stall(ctl_v[2]));
   hazard_sequencer #(.WB_DEPTH(1)) u_wb1 (.clk(clk), .reset_n(reset_n), .id_valid(id_valid),
      .id_inst(id_inst), .stall_id_if_pl(stall_v[3]), .stall_pc_increment(pc_v[3]), .halt(halt_v[3]),
      .dbg_dep_stall(dep_v[3]), .dbg_ctrl_stall(ctl_v[3]));
   hazard_sequencer #(.WB_DEPTH(4), .FWD_EN(1), .LOAD_USE_WIN(2), .BRANCH_PENALTY(2),
      .JUMP_PENALTY(3), .HALT_DRAIN(1)) u_wb4 (.clk(clk), .reset_n(reset_n), .id_valid(id_valid),
      .id_inst(id_inst), .stall_id_if_pl(stall_v[4]), .stall_pc_increment(pc_v[4]), .halt(halt_v[4]),
      .dbg_dep_stall(dep_v[4]), .dbg_ctrl_stall(ctl_v[4]));

   // Reference model: list of issued writers with their issue cycle.
   typedef struct { int rd; bit ld; int t; } wr_t;
   wr_t wq[$];
   int  cyc, ctrl_until, halt_t;
   int  p_wb, p_fwd, p_luw, p_bp, p_jp, p_hd;

   function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
   endfunction

   function automatic bit m_reads1(input logic [6:0] op);
      return op inside {OP_OP, OP_BR, OP_ST, OP_IMM, OP_JALR, OP_LD};
   endfunction

   function automatic bit m_reads2(input logic [6:0] op);
      return op inside {OP_OP, OP_BR, OP_ST};
   endfunction

   function automatic bit m_writes(input logic [6:0] op);
      return op inside {OP_OP, OP_IMM, OP_LUI, OP_AUI, OP_LD, OP_JAL, OP_JALR};
   endfunction

   function automatic bit m_dep(input logic v, input logic [31:0] inst);
      int r1, r2, age;
      bit live, hit;
      r1  = int'(inst[19:15]);
      r2  = int'(inst[24:20]);
      hit = 1'b0;
      if (v) begin
         foreach (wq[j]) begin
            age  = cyc - wq[j].t - 1;
            live = (age >= 0) && (age < p_wb) && ((p_fwd == 0) || (wq[j].ld && (age < p_luw)));
            if (live && ((m_reads1(inst[6:0]) && r1 != 0 && r1 == wq[j].rd) ||
                         (m_reads2(inst[6:0]) && r2 != 0 && r2 == wq[j].rd))) hit = 1'b1;
         end
      end
      return hit;
   endfunction

   task automatic m_commit(input logic v, input logic [31:0] inst);
      bit  st;
      wr_t w;
      st = (halt_t >= 0) || (cyc <= ctrl_until) || m_dep(v, inst);
      if (v && !st) begin
         if (m_writes(inst[6:0]) && inst[11:7] != 5'd0) begin
            w.rd = int'(inst[11:7]);
            w.ld = (inst[6:0] == OP_LD);
            w.t  = cyc;
            wq.push_back(w);
         end
         if (inst[6:0] == OP_BR) ctrl_until = cyc + p_bp;
         if (inst[6:0] == OP_JAL || inst[6:0] == OP_JALR) ctrl_until = cyc + p_jp;
         if (inst == INV) halt_t = cyc;
      end
      cyc++;
      while (wq.size() > 0 && (cyc - wq[0].t - 1) >= p_wb) void'(wq.pop_front());
   endtask

   task automatic set_cfg(input int k);
      p_wb = 2; p_fwd = 0; p_luw = 1; p_bp = 1; p_jp = 1; p_hd = 2;
      case (k)
         1: p_fwd = 1;
         2: begin p_bp = 3; p_jp = 0; p_hd = 3; end
         3: p_wb = 1;
         4: begin p_wb = 4; p_fwd = 1; p_luw = 2; p_bp = 2; p_jp = 3; p_hd = 1; end
         default: ;
      endcase
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      id_valid = 1'b0;
      id_inst  = '0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      cyc = 0; ctrl_until = -1; halt_t = -1;
      wq.delete();
   endtask

   task automatic put(input logic v, input logic [31:0] inst);
      id_valid = v;
      id_inst  = inst;
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] op;
      case ($urandom_range(0, 8))
         0: op = OP_LUI;  1: op = OP_AUI;  2: op = OP_JAL;
         3: op = OP_JALR; 4: op = OP_BR;   5: op = OP_LD;
         6: op = OP_ST;   7: op = OP_IMM;  default: op = OP_OP;
      endcase
      if ($urandom_range(0, 59) == 0) return INV;
      return enc(op, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
   endfunction

   task automatic test_reset();
      do_reset();
      put(1'b0, '0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if ({stall_v[k], pc_v[k], halt_v[k], dep_v[k], ctl_v[k]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs[%0d] got=%b want=00000", k,
                     {stall_v[k], pc_v[k], halt_v[k], dep_v[k], ctl_v[k]});
         end
      end
   endtask

   task automatic test_dependency();
      do_reset();
      put(1'b1, enc(OP_OP, 5, 1, 2));
      checks++; if (stall_v[0] !== 1'b0) begin errors++; $display("FAIL dep_c0 stall=%b want 0", stall_v[0]); end
      adv();
      put(1'b1, enc(OP_IMM, 6, 5, 1));
      checks++; if (stall_v[0] !== 1'b1) begin errors++; $display("FAIL dep_c1 stall=%b want 1", stall_v[0]); end
      checks++; if (dep_v[0] !== 1'b1) begin errors++; $display("FAIL dep_c1_dbg dep=%b want 1", dep_v[0]); end
      checks++; if (pc_v[0] !== 1'b1) begin errors++; $display("FAIL dep_c1_pc pc=%b want 1", pc_v[0]); end
      checks++; if (stall_v[3] !== 1'b1) begin errors++; $display("FAIL dep_wb1_c1 stall=%b want 1", stall_v[3]); end
      adv();
      checks++; if (stall_v[0] !== 1'b1) begin errors++; $display("FAIL dep_c2 stall=%b want 1", stall_v[0]); end
      checks++; if (stall_v[3] !== 1'b0) begin errors++; $display("FAIL dep_wb1_c2 stall=%b want 0", stall_v[3]); end
      adv();
      checks++; if (stall_v[0] !== 1'b0) begin errors++; $display("FAIL dep_c3_retire stall=%b want 0", stall_v[0]); end
   endtask

   task automatic test_forwarding();
      do_reset();
      put(1'b1, enc(OP_OP, 5, 1, 2));
      adv();
      put(1'b1, enc(OP_IMM, 6, 5, 1));
      checks++; if (stall_v[1] !== 1'b0) begin errors++; $display("FAIL fwd_alu stall=%b want 0", stall_v[1]); end
      adv();
      put(1'b1, enc(OP_LD, 5, 1, 0));
      checks++; if (stall_v[1] !== 1'b0) begin errors++; $display("FAIL fwd_lw stall=%b want 0", stall_v[1]); end
      adv();
      put(1'b1, enc(OP_OP, 7, 5, 3));
      checks++; if (stall_v[1] !== 1'b1) begin errors++; $display("FAIL fwd_loaduse stall=%b want 1", stall_v[1]); end
      checks++; if (stall_v[4] !== 1'b1) begin errors++; $display("FAIL fwd_win2_c0 stall=%b want 1", stall_v[4]); end
      adv();
      checks++; if (stall_v[1] !== 1'b0) begin errors++; $display("FAIL fwd_loaduse_done stall=%b want 0", stall_v[1]); end
      checks++; if (stall_v[4] !== 1'b1) begin errors++; $display("FAIL fwd_win2_c1 stall=%b want 1", stall_v[4]); end
   endtask

   task automatic test_x0();
      do_reset();
      put(1'b1, enc(OP_OP, 0, 1, 2));
      adv();
      put(1'b1, enc(OP_OP, 3, 0, 0));
      checks++; if (stall_v[0] !== 1'b0) begin errors++; $display("FAIL x0_stall stall=%b want 0", stall_v[0]); end
      checks++; if (dep_v[0] !== 1'b0) begin errors++; $display("FAIL x0_dep dep=%b want 0", dep_v[0]); end
   endtask

   task automatic test_control();
      do_reset();
      put(1'b1, enc(OP_BR, 0, 3, 4));
      checks++; if (ctl_v[2] !== 1'b0) begin errors++; $display("FAIL br_c0 ctl=%b want 0", ctl_v[2]); end
      adv();
      for (int c = 1; c <= 3; c++) begin
         put(1'b1, enc(OP_OP, 8, 1, 2));
         checks++;
         if ({stall_v[2], ctl_v[2]} !== 2'b11) begin
            errors++; $display("FAIL br_window c%0d stall,ctl=%b want 11", c, {stall_v[2], ctl_v[2]});
         end
         adv();
      end
      checks++; if ({stall_v[2], ctl_v[2]} !== 2'b00) begin errors++; $display("FAIL br_end stall,ctl=%b want 00", {stall_v[2], ctl_v[2]}); end
      // overlap of dependency and penalty
      do_reset();
      put(1'b1, enc(OP_OP, 5, 1, 2));
      adv();
      put(1'b1, enc(OP_BR, 0, 3, 4));
      checks++; if (stall_v[2] !== 1'b0) begin errors++; $display("FAIL ovl_br stall=%b want 0", stall_v[2]); end
      adv();
      put(1'b1, enc(OP_OP, 6, 5, 1));
      checks++; if ({dep_v[2], ctl_v[2]} !== 2'b11) begin errors++; $display("FAIL ovl_c2 dep,ctl=%b want 11", {dep_v[2], ctl_v[2]}); end
      adv();
      checks++; if ({dep_v[2], ctl_v[2]} !== 2'b01) begin errors++; $display("FAIL ovl_c3 dep,ctl=%b want 01", {dep_v[2], ctl_v[2]}); end
      adv();
      checks++; if (stall_v[2] !== 1'b1) begin errors++; $display("FAIL ovl_c4 stall=%b want 1", stall_v[2]); end
      adv();
      checks++; if (stall_v[2] !== 1'b0) begin errors++; $display("FAIL ovl_c5 stall=%b want 0", stall_v[2]); end
      // zero jump penalty
      do_reset();
      put(1'b1, enc(OP_JAL, 1, 0, 0));
      adv();
      put(1'b1, enc(OP_OP, 8, 2, 3));
      checks++; if ({stall_v[2], ctl_v[2]} !== 2'b00) begin errors++; $display("FAIL jal_pen0 stall,ctl=%b want 00", {stall_v[2], ctl_v[2]}); end
   endtask

   task automatic test_halt();
      do_reset();
      put(1'b1, INV);
      checks++; if (stall_v[0] !== 1'b0) begin errors++; $display("FAIL halt_issue stall=%b want 0", stall_v[0]); end
      adv();
      for (int c = 1; c <= 2; c++) begin
         put(1'b0, '0);
         checks++;
         if ({stall_v[0], halt_v[0]} !== 2'b10) begin
            errors++; $display("FAIL halt_drain c%0d stall,halt=%b want 10", c, {stall_v[0], halt_v[0]});
         end
         adv();
      end
      checks++; if ({stall_v[0], halt_v[0]} !== 2'b11) begin errors++; $display("FAIL halt_c3 stall,halt=%b want 11", {stall_v[0], halt_v[0]}); end
      checks++; if (halt_v[2] !== 1'b0) begin errors++; $display("FAIL halt_hd3_c3 halt=%b want 0", halt_v[2]); end
      adv();
      checks++; if (halt_v[2] !== 1'b1) begin errors++; $display("FAIL halt_hd3_c4 halt=%b want 1", halt_v[2]); end
      // reset during drain
      do_reset();
      put(1'b1, INV);
      adv();
      put(1'b0, '0);
      checks++; if (stall_v[0] !== 1'b1) begin errors++; $display("FAIL mid_drain stall=%b want 1", stall_v[0]); end
      do_reset();
      put(1'b0, '0);
      checks++; if ({stall_v[0], halt_v[0]} !== 2'b00) begin errors++; $display("FAIL drain_reset stall,halt=%b want 00", {stall_v[0], halt_v[0]}); end
      // a stalled INVALID_INST is not a halt request
      do_reset();
      put(1'b1, enc(OP_BR, 0, 1, 2));
      adv();
      put(1'b1, INV);
      checks++; if (stall_v[2] !== 1'b1) begin errors++; $display("FAIL inv_stalled stall=%b want 1", stall_v[2]); end
      adv();
      put(1'b0, '0);
      adv();
      adv();
      adv();
      put(1'b1, enc(OP_OP, 8, 1, 2));
      checks++; if ({stall_v[2], halt_v[2]} !== 2'b00) begin errors++; $display("FAIL inv_ignored stall,halt=%b want 00", {stall_v[2], halt_v[2]}); end
   endtask

   task automatic test_random(input int k, input int n);
      logic        v;
      logic [31:0] inst;
      bit          e_dep, e_ctl, e_halt, e_st;
      set_cfg(k);
      do_reset();
      for (int c = 0; c < n; c++) begin
         if (halt_t >= 0 && cyc > halt_t + p_hd + 2) do_reset();
         v    = ($urandom_range(0, 9) < 8);
         inst = rand_inst();
         put(v, inst);
         e_dep  = m_dep(v, inst);
         e_ctl  = (cyc <= ctrl_until);
         e_halt = (halt_t >= 0) && (cyc > halt_t + p_hd);
         e_st   = (halt_t >= 0) || e_ctl || e_dep;
         checks++;
         if ({stall_v[k], pc_v[k], halt_v[k], dep_v[k], ctl_v[k]} !== {e_st, e_st, e_halt, e_dep, e_ctl}) begin
            errors++;
            $display("FAIL rand[%0d] cyc=%0d inst=%h v=%b stall,pc,halt,dep,ctl=%b want %b", k, cyc, inst, v,
                     {stall_v[k], pc_v[k], halt_v[k], dep_v[k], ctl_v[k]}, {e_st, e_st, e_halt, e_dep, e_ctl});
         end
         m_commit(v, inst);
         adv();
      end
   endtask

   initial begin
      set_cfg(0);
      @(negedge clk);
      test_reset();
      test_dependency();
      test_forwarding();
      test_x0();
      test_control();
      test_halt();
      for (int k = 0; k < NI; k++) test_random(k, 400);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
